// File: rtl/pong_responder.sv
// Responder side of the ping/pong exchange: each accepted ping returns one pong after RESP_DELAY cycles.
// Optional pending-ping queue enabled by defining PONG_QUEUE_EN.
module pong_responder #(
    parameter int RESP_DELAY = 2,
    parameter int MAX_COUNT  = 10,
    parameter int CNT_W      = 8,
    parameter int QDEPTH     = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr_i,
    input  logic                         ping_i,
    output logic                         pong_o,
    output logic [CNT_W-1:0]             cnt_o,
    output logic                         done_o,
    output logic                         busy_o,
    output logic                         overrun_o,
    output logic [$clog2(QDEPTH+1)-1:0]  pend_o
);

    localparam int PW    = $clog2(QDEPTH + 1);
    localparam int DLY_W = (RESP_DELAY > 2) ? $clog2(RESP_DELAY) : 1;
    // First delay counts from the ping edge; a back-to-back delay counts from the RESP cycle.
    localparam logic [DLY_W-1:0] DLY_LOAD   = DLY_W'(RESP_DELAY - 1);
    localparam logic [DLY_W-1:0] DLY_RELOAD = DLY_W'((RESP_DELAY >= 2) ? RESP_DELAY - 2 : 0);

    typedef enum logic [1:0] {IDLE, WAIT, RESP, DONE} state_t;

    state_t             state_reg, state_next;
    logic [DLY_W-1:0]   dly_reg, dly_next;
    logic               pong_reg, pong_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               done_reg, done_next;
    logic               busy_reg, busy_next;
    logic               ovr_reg, ovr_next;
    logic [PW-1:0]      pend_reg, pend_next;

    logic               q_push, q_drop, q_avail, take;
    logic [CNT_W-1:0]   cnt_inc;
    logic               hit_max;

    assign cnt_inc = cnt_reg + CNT_W'(1);
    assign hit_max = (cnt_inc == CNT_W'(MAX_COUNT));

`ifdef PONG_QUEUE_EN
    assign q_push  = ping_i && (pend_reg < PW'(QDEPTH));
    assign q_drop  = ping_i && (pend_reg >= PW'(QDEPTH));
    assign q_avail = (pend_reg != '0);
`else
    assign q_push  = 1'b0;
    assign q_drop  = ping_i;
    assign q_avail = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        dly_next   = dly_reg;
        pong_next  = 1'b0;
        cnt_next   = cnt_reg;
        done_next  = done_reg;
        ovr_next   = ovr_reg;
        pend_next  = pend_reg;
        take       = 1'b0;

        if (clr_i) begin
            state_next = IDLE;
            dly_next   = '0;
            cnt_next   = '0;
            done_next  = 1'b0;
            ovr_next   = 1'b0;
            pend_next  = '0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (ping_i) begin
                        state_next = WAIT;
                        dly_next   = DLY_LOAD;
                    end
                end
                WAIT: begin
                    pend_next = pend_reg + PW'(q_push);
                    if (q_drop) ovr_next = 1'b1;
                    if (dly_reg == '0) begin
                        state_next = RESP;
                        pong_next  = 1'b1;
                        cnt_next   = cnt_inc;
                        if (hit_max) done_next = 1'b1;
                    end else begin
                        dly_next = dly_reg - DLY_W'(1);
                    end
                end
                RESP: begin
                    if (done_reg) begin
                        // Final pong already out: pings are ignored and the queue is discarded.
                        state_next = DONE;
                        pend_next  = '0;
                    end else begin
                        take      = q_avail || q_push;
                        pend_next = pend_reg + PW'(q_push) - PW'(take);
                        if (q_drop) ovr_next = 1'b1;
                        if (!take) begin
                            state_next = IDLE;
                        end else if (RESP_DELAY == 1) begin
                            state_next = RESP;
                            pong_next  = 1'b1;
                            cnt_next   = cnt_inc;
                            if (hit_max) done_next = 1'b1;
                        end else begin
                            state_next = WAIT;
                            dly_next   = DLY_RELOAD;
                        end
                    end
                end
                DONE: begin
                    state_next = DONE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end

        busy_next = (state_next == WAIT) || (state_next == RESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            dly_reg   <= '0;
            pong_reg  <= 1'b0;
            cnt_reg   <= '0;
            done_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            ovr_reg   <= 1'b0;
            pend_reg  <= '0;
        end else begin
            state_reg <= state_next;
            dly_reg   <= dly_next;
            pong_reg  <= pong_next;
            cnt_reg   <= cnt_next;
            done_reg  <= done_next;
            busy_reg  <= busy_next;
            ovr_reg   <= ovr_next;
            pend_reg  <= pend_next;
        end
    end

    assign pong_o    = pong_reg;
    assign cnt_o     = cnt_reg;
    assign done_o    = done_reg;
    assign busy_o    = busy_reg;
    assign overrun_o = ovr_reg;
    assign pend_o    = pend_reg;

endmodule

// File: tb/tb_pong_responder.sv
// Self-checking bench for pong_responder: vector table, hand sequences and randomized run against
// an event-time reference model (model covers the default build; PONG_QUEUE_EN uses hand checks).
module tb_pong_responder;

    localparam int RESP_DELAY = 2;
    localparam int MAX_COUNT  = 10;
    localparam int CNT_W      = 8;
    localparam int QDEPTH     = 4;
    localparam int PW         = $clog2(QDEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clr_i = 1'b0;
    logic             ping_i = 1'b0;
    logic             pong_o;
    logic [CNT_W-1:0] cnt_o;
    logic             done_o;
    logic             busy_o;
    logic             overrun_o;
    logic [PW-1:0]    pend_o;

    pong_responder #(
        .RESP_DELAY(RESP_DELAY),
        .MAX_COUNT (MAX_COUNT),
        .CNT_W     (CNT_W),
        .QDEPTH    (QDEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (clr_i),
        .ping_i    (ping_i),
        .pong_o    (pong_o),
        .cnt_o     (cnt_o),
        .done_o    (done_o),
        .busy_o    (busy_o),
        .overrun_o (overrun_o),
        .pend_o    (pend_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;
    int t     = 0;

    // Reference model: the edge index at which the outstanding pong is due, plus counters.
    int m_pong = -1;
    int m_cnt  = 0;
    bit m_done = 1'b0;
    bit m_ovr  = 1'b0;
    bit e_pong, e_busy;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s @edge %0d: got %0d expected %0d", nm, t, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pong = -1;
        m_cnt  = 0;
        m_done = 1'b0;
        m_ovr  = 1'b0;
    endtask

    task automatic model_edge(input bit c, input bit p);
        bit bsy;
        // Busy from the accepting edge until the edge after the pong edge.
        bsy = (m_pong >= 0) && (t <= m_pong + 1);
        if (c) begin
            model_reset();
        end else if (!m_done && p) begin
            if (bsy) m_ovr = 1'b1;
            else     m_pong = t + RESP_DELAY;
        end
        e_pong = (m_pong == t);
        if (e_pong) begin
            m_cnt++;
            if (m_cnt == MAX_COUNT) m_done = 1'b1;
        end
        e_busy = (m_pong >= 0) && (t <= m_pong);
    endtask

    task automatic step(input bit c, input bit p);
        @(negedge clk);
        clr_i  = c;
        ping_i = p;
        @(posedge clk);
        #1;
        t++;
        clr_i  = 1'b0;
        ping_i = 1'b0;
`ifndef PONG_QUEUE_EN
        model_edge(c, p);
        chk("model_pong", pong_o, e_pong);
        chk("model_cnt", cnt_o, m_cnt);
        chk("model_done", done_o, m_done);
        chk("model_busy", busy_o, e_busy);
        chk("model_ovr", overrun_o, m_ovr);
        chk("model_pend", pend_o, 0);
`endif
    endtask

    typedef struct {
        bit clr;
        bit ping;
        bit e_pong;
        int e_cnt;
        bit e_busy;
        bit e_ovr;
    } vec_t;

    vec_t tbl [15];

    initial begin
        int pongs;
        int cd;
        bit p;

        // Reset state
        #23;
        chk("rst_pong", pong_o, 0);
        chk("rst_cnt", cnt_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_ovr", overrun_o, 0);
        chk("rst_pend", pend_o, 0);
        @(negedge clk);
        rst_n = 1'b1;

`ifndef PONG_QUEUE_EN
        // Latency, drop-while-busy overrun, clear with ping, clear cancelling an in-flight pong.
        tbl[0]  = '{0, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 1, 0, 0, 1, 0};
        tbl[2]  = '{0, 0, 0, 0, 1, 0};
        tbl[3]  = '{0, 0, 1, 1, 1, 0};
        tbl[4]  = '{0, 0, 0, 1, 0, 0};
        tbl[5]  = '{0, 1, 0, 1, 1, 0};
        tbl[6]  = '{0, 1, 0, 1, 1, 1};
        tbl[7]  = '{0, 0, 1, 2, 1, 1};
        tbl[8]  = '{0, 0, 0, 2, 0, 1};
        tbl[9]  = '{1, 1, 0, 0, 0, 0};
        tbl[10] = '{0, 0, 0, 0, 0, 0};
        tbl[11] = '{0, 1, 0, 0, 1, 0};
        tbl[12] = '{1, 0, 0, 0, 0, 0};
        tbl[13] = '{0, 0, 0, 0, 0, 0};
        tbl[14] = '{0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 15; i++) begin
            step(tbl[i].clr, tbl[i].ping);
            chk($sformatf("tbl%0d_pong", i), pong_o, tbl[i].e_pong);
            chk($sformatf("tbl%0d_cnt", i), cnt_o, tbl[i].e_cnt);
            chk($sformatf("tbl%0d_busy", i), busy_o, tbl[i].e_busy);
            chk($sformatf("tbl%0d_ovr", i), overrun_o, tbl[i].e_ovr);
        end
`else
        // Three back-to-back pings: pongs two cycles apart, queue depth 1,2,1,0.
        begin
            int exp_pend [8] = '{0, 1, 2, 1, 1, 0, 0, 0};
            bit exp_pg   [8] = '{0, 0, 1, 0, 1, 0, 1, 0};
            for (int i = 0; i < 8; i++) begin
                step(1'b0, i < 3);
                chk($sformatf("q3_pend%0d", i), pend_o, exp_pend[i]);
                chk($sformatf("q3_pong%0d", i), pong_o, exp_pg[i]);
            end
            chk("q3_ovr", overrun_o, 0);
            chk("q3_cnt", cnt_o, 3);
        end
        // Ten back-to-back pings overflow the four-entry queue twice.
        step(1'b1, 1'b0);
        pongs = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, i < 10);
            if (pong_o) pongs++;
        end
        chk("q10_pongs", pongs, 8);
        chk("q10_ovr", overrun_o, 1);
        chk("q10_pend", pend_o, 0);
        step(1'b1, 1'b0);
        chk("q10_clr_ovr", overrun_o, 0);
`endif

        // Initiator re-pings one cycle after each pong until done.
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        pongs = 0;
        cd = -1;
        for (int i = 0; i < 120; i++) begin
            p = (cd == 0);
            step(1'b0, p);
            if (cd >= 0) cd--;
            if (pong_o) begin
                pongs++;
                chk($sformatf("rt_done_with_pong%0d", pongs), done_o, pongs >= MAX_COUNT);
                cd = 1;
            end
        end
        chk("rt_pongs", pongs, MAX_COUNT);
        chk("rt_cnt", cnt_o, MAX_COUNT);
        chk("rt_done", done_o, 1);
        chk("rt_ovr", overrun_o, 0);
        chk("rt_busy", busy_o, 0);

        // Clear and ping in the same cycle with cnt_o at 4.
        step(1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1);
            for (int j = 0; j < 4; j++) step(1'b0, 1'b0);
        end
        chk("clr_pre_cnt", cnt_o, 4);
        step(1'b1, 1'b1);
        chk("clr_cnt", cnt_o, 0);
        chk("clr_busy", busy_o, 0);
        chk("clr_pong", pong_o, 0);
        pongs = 0;
        for (int j = 0; j < 5; j++) begin
            step(1'b0, 1'b0);
            if (pong_o) pongs++;
        end
        chk("clr_no_pong", pongs, 0);

        // Asynchronous reset during WAIT.
        step(1'b0, 1'b1);
        chk("arst_pre_busy", busy_o, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_pong", pong_o, 0);
        chk("arst_cnt", cnt_o, 0);
        chk("arst_done", done_o, 0);
        chk("arst_busy", busy_o, 0);
        chk("arst_ovr", overrun_o, 0);
        chk("arst_pend", pend_o, 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pongs = 0;
        for (int j = 0; j < 20; j++) begin
            step(1'b0, 1'b0);
            if (pong_o) pongs++;
        end
        chk("arst_no_pong", pongs, 0);

`ifndef PONG_QUEUE_EN
        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
